// File: rtl/spi_reg_slave_if.sv
// rtl/spi_reg_slave_if.sv - SPI pins and register-file strobe bus of the SPI register slave
interface spi_reg_slave_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              SCLK;
  logic              MOSI;
  logic              SS;
  logic              MISO;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [DATA_W-1:0] reg_rd_data;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  SCLK, MOSI, SS, reg_rd_data,
    output MISO, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, busy, frame_err
  );

  modport master (
    output SCLK, MOSI, SS, reg_rd_data,
    input  MISO, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, busy, frame_err
  );
endinterface

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - oversampled SPI mode-0 slave turning 32-bit frames into register strobes
module spi_reg_slave #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16,
  parameter int SYNC_W = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_reg_slave_if.slave bus
);

  localparam int HDR_W   = 2 + ADDR_W;
  localparam int FRAME_W = HDR_W + DATA_W;
  localparam int SHIFT_W = (HDR_W > DATA_W) ? HDR_W : DATA_W;
  localparam logic [5:0] HDR_LAST   = 6'(HDR_W - 1);
  localparam logic [5:0] FRAME_LAST = 6'(FRAME_W - 1);

  typedef enum logic [2:0] {IDLE, HDR, WDATA, RFETCH, RSHIFT, DRAIN} state_t;

  logic [SYNC_W-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic              sclk_prev_q, ss_prev_q;
  logic              sclk_s, mosi_s, ss_s;
  logic              sclk_rise, sclk_fall, ss_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_W-2:0], bus.SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_W-2:0], bus.MOSI};
      ss_sync_q   <= {ss_sync_q[SYNC_W-2:0], bus.SS};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_W-1];
  assign mosi_s    = mosi_sync_q[SYNC_W-1];
  assign ss_s      = ss_sync_q[SYNC_W-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;

  state_t             state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [SHIFT_W-1:0] rx_q, rx_d, rx_next;
  logic [DATA_W-1:0]  tx_q, tx_d;
  logic               miso_q, miso_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               wr_en_q, wr_en_d;
  logic               rd_en_q, rd_en_d;
  logic               err_q, err_d;

  assign rx_next = {rx_q[SHIFT_W-2:0], mosi_s};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    tx_d    = tx_q;
    miso_d  = miso_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall) begin
          state_d = HDR;
          cnt_d   = '0;
          rx_d    = '0;
          tx_d    = '0;
        end
      end
      HDR, WDATA, RFETCH, RSHIFT: begin
        if (ss_s) begin
          // SS released before the last bit: the frame is dropped, never written
          err_d   = 1'b1;
          miso_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 6'd1;
          end
          case (state_q)
            HDR: begin
              if (sclk_rise) begin
                rx_d = rx_next;
                if (cnt_q == HDR_LAST) begin
                  addr_d = rx_next[ADDR_W-1:0];
                  case (rx_next[HDR_W-1 -: 2])
                    2'b00: state_d = WDATA;
                    2'b01: begin
                      state_d = RFETCH;
                      rd_en_d = 1'b1;
                    end
                    default: begin
                      err_d   = 1'b1;
                      state_d = DRAIN;
                    end
                  endcase
                end
              end
            end
            WDATA: begin
              if (sclk_rise) begin
                rx_d = rx_next;
                if (cnt_q == FRAME_LAST) begin
                  wdata_d = rx_next[DATA_W-1:0];
                  wr_en_d = 1'b1;
                  state_d = DRAIN;
                end
              end
            end
            RFETCH: begin
              // read data lands one clk after the strobe, so load once the strobe has dropped
              if (!rd_en_q) begin
                tx_d    = bus.reg_rd_data;
                state_d = RSHIFT;
              end
            end
            default: begin
              if (sclk_rise) begin
                if (cnt_q == FRAME_LAST) begin
                  miso_d  = 1'b0;
                  state_d = DRAIN;
                end
              end else if (sclk_fall) begin
                miso_d = tx_q[DATA_W-1];
                tx_d   = {tx_q[DATA_W-2:0], 1'b0};
              end
            end
          endcase
        end
      end
      default: begin
        miso_d = 1'b0;
        if (ss_s) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      tx_q    <= '0;
      miso_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      miso_q  <= miso_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      err_q   <= err_d;
    end
  end

  // gating with the raw pin keeps MISO quiet the instant SS deasserts
  assign bus.MISO        = miso_q & ~bus.SS;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_wr_data = wdata_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - randomized bench for spi_reg_slave against a frame-level reference model
module tb_spi_reg_slave;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int SYNC_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_reg_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_reg_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_W(SYNC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] init_val(input int a);
    if (a == 18) return 16'hA5C3;
    return 16'(a * 40503) ^ 16'h3C96;
  endfunction

  // register file the DUT talks to
  logic [15:0] env_mem [0:16383];
  bit          env_written [0:16383];
  always @(posedge clk) begin
    if (bus.reg_wr_en) begin
      env_mem[bus.reg_addr]     <= bus.reg_wr_data;
      env_written[bus.reg_addr] <= 1'b1;
    end
    if (bus.reg_rd_en)
      bus.reg_rd_data <= env_written[bus.reg_addr] ? env_mem[bus.reg_addr] : init_val(int'(bus.reg_addr));
  end

  // strobe monitor
  int          wr_cnt = 0, rd_cnt = 0, err_cnt = 0, overlap = 0, miso_bad = 0;
  logic [13:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  bit          quiet = 1'b1;
  always @(negedge clk) begin
    if (bus.reg_wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus.reg_addr;
      wr_data <= bus.reg_wr_data;
    end
    if (bus.reg_rd_en) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= bus.reg_addr;
    end
    if (bus.frame_err) err_cnt <= err_cnt + 1;
    if (bus.reg_wr_en && bus.reg_rd_en) overlap <= overlap + 1;
    if (bus.MISO && (bus.SS || quiet)) miso_bad <= miso_bad + 1;
  end

  // reference model: register contents and last latched address
  logic [15:0] model_mem [0:16383];
  bit          model_written [0:16383];
  logic [13:0] model_addr = '0;

  function automatic logic [15:0] model_rd(input int a);
    return model_written[a] ? model_mem[a] : init_val(a);
  endfunction

  task automatic send_bits(input logic [31:0] w, input int nbits, input int half, output logic [15:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.MOSI = (i < 32) ? w[31-i] : 1'($urandom);
      repeat (half) @(posedge clk);
      #1 bus.SCLK = 1'b1;
      if (i >= 16 && i < 32) rx = {rx[14:0], bus.MISO};
      repeat (half) @(posedge clk);
      #1 bus.SCLK = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] w, input int nbits, input int half);
    logic [1:0]  cmd;
    logic [13:0] addr;
    logic [15:0] rx;
    int wr0, rd0, er0, ov0, mb0;
    bit full, hdr, exp_wr, exp_rd, exp_err;
    cmd  = w[31:30];
    addr = w[29:16];
    full = (nbits >= 32);
    hdr  = (nbits >= 16);
    exp_wr  = (cmd == 2'b00) && full;
    exp_rd  = (cmd == 2'b01) && hdr;
    exp_err = cmd[1] || !full;
    wr0 = wr_cnt; rd0 = rd_cnt; er0 = err_cnt; ov0 = overlap; mb0 = miso_bad;
    quiet = (cmd != 2'b01);
    @(posedge clk);
    #1 bus.SS = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("busy_start", bus.busy, 1);
    send_bits(w, nbits, half, rx);
    repeat (half) @(posedge clk);
    @(negedge clk);
    check_val("busy_before_ss_rise", bus.busy, 1);
    @(posedge clk);
    #1 bus.SS = 1'b1;
    repeat (SYNC_W + 2) @(posedge clk);
    @(negedge clk);
    check_val("busy_after_ss_rise", bus.busy, 0);
    check_val("wr_strobes", wr_cnt - wr0, exp_wr);
    check_val("rd_strobes", rd_cnt - rd0, exp_rd);
    check_val("frame_err_pulses", err_cnt - er0, exp_err);
    check_val("wr_rd_overlap", overlap - ov0, 0);
    check_val("miso_quiet", miso_bad - mb0, 0);
    if (exp_wr) begin
      check_val("wr_addr", wr_addr, addr);
      check_val("wr_data", wr_data, w[15:0]);
      model_mem[addr]     = w[15:0];
      model_written[addr] = 1'b1;
    end
    if (exp_rd) check_val("rd_addr", rd_addr, addr);
    if (cmd == 2'b01 && full) check_val("rd_miso_word", rx, model_rd(int'(addr)));
    if (hdr) model_addr = addr;
    check_val("reg_addr_held", bus.reg_addr, model_addr);
    quiet = 1'b1;
  endtask

  task automatic reset_mid_frame();
    logic [15:0] rx;
    int wr0, er0;
    wr0 = wr_cnt; er0 = err_cnt;
    @(posedge clk);
    #1 bus.SS = 1'b0;
    repeat (4) @(posedge clk);
    send_bits(32'h0009_ABCD, 10, 8, rx);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("outs_in_reset", {bus.reg_addr, bus.reg_wr_data, bus.reg_wr_en, bus.reg_rd_en,
                                bus.busy, bus.frame_err, bus.MISO}, 0);
    bus.SS = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    model_addr = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("reset_no_write", wr_cnt - wr0, 0);
    check_val("reset_no_err", err_cnt - er0, 0);
    check_val("reset_idle", bus.busy, 0);
  endtask

  initial begin
    logic [31:0] w;
    int nb, r;
    rst_n    = 1'b0;
    bus.SCLK = 1'b0;
    bus.MOSI = 1'b0;
    bus.SS   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_state", {bus.reg_addr, bus.reg_wr_data, bus.reg_wr_en, bus.reg_rd_en,
                              bus.busy, bus.frame_err, bus.MISO}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    frame(32'h0005_BEEF, 32, 8);
    frame(32'h4012_0000, 32, 9);
    frame(32'h0007_0000, 20, 8);
    frame(32'hC001_1234, 32, 8);
    reset_mid_frame();
    frame(32'h0001_0001, 32, 8);
    frame(32'h0003_1111, 32, 8);
    frame(32'h4003_0000, 32, 8);

    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      w[31:30] = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : 2'($urandom_range(2, 3));
      w[29:16] = 14'($urandom_range(0, 31));
      w[15:0]  = 16'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : 32;
      frame(w, nb, $urandom_range(8, 11));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
